// File: rtl/trail_collision_detect.sv
// Light-cycle trail collision detector: 1-bit occupancy map of both trails,
// bounds/occupancy check per head move, sticky crash flags for the game-mode FSM.
package game_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;
endpackage

module trail_collision_detect
  import game_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48,
  parameter int XW     = 6,
  parameter int YW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  game_mode      mode,
  input  logic [XW-1:0] p1_x,
  input  logic [YW-1:0] p1_y,
  input  logic          p1_move,
  input  logic [XW-1:0] p2_x,
  input  logic [YW-1:0] p2_y,
  input  logic          p2_move,
  output logic          move_ready,
  output logic          player1_collision,
  output logic          player2_collision,
  output logic          clear_busy
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_CMP} state_t;

  state_t        state_q, state_d;
  game_mode      mode_q, mode_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d;
  logic          flag1_q, flag1_d;
  logic          flag2_q, flag2_d;
  logic          cur_p2_q, cur_p2_d;
  logic          p2_pend_q, p2_pend_d;
  logic          head_on_q, head_on_d;
  logic          oob_q, oob_d;
  logic [XW-1:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d;
  logic [YW-1:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;

  logic          map_mem [CELLS];
  logic          ram_q;
  logic          ram_we;
  logic          ram_wdata;
  logic [AW-1:0] ram_addr;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          start_entry;
  logic          hit;

  function automatic logic out_of_bounds(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (int'(x) >= GRID_W) || (int'(y) >= GRID_H);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(int'(y) * GRID_W + int'(x));
  endfunction

  assign move_ready        = (state_q == S_IDLE) && (mode == GAME);
  assign clear_busy        = (state_q == S_CLEAR);
  assign player1_collision = flag1_q;
  assign player2_collision = flag2_q;

  assign cur_x       = cur_p2_q ? p2_x_q : p1_x_q;
  assign cur_y       = cur_p2_q ? p2_y_q : p1_y_q;
  assign start_entry = (mode == START) && (mode_q != START);
  assign hit         = oob_q || ram_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode;
    clear_addr_d = clear_addr_q;
    flag1_d      = flag1_q;
    flag2_d      = flag2_q;
    cur_p2_d     = cur_p2_q;
    p2_pend_d    = p2_pend_q;
    head_on_d    = head_on_q;
    oob_d        = oob_q;
    p1_x_d       = p1_x_q;
    p1_y_d       = p1_y_q;
    p2_x_d       = p2_x_q;
    p2_y_d       = p2_y_q;
    ram_we       = 1'b0;
    ram_wdata    = 1'b0;
    ram_addr     = cell_addr(cur_x, cur_y);

    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clear_addr_q;
        flag1_d   = 1'b0;
        flag2_d   = 1'b0;
        if (clear_addr_q == AW'(CELLS - 1)) begin
          clear_addr_d = '0;
          state_d      = S_IDLE;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (move_ready && (p1_move || p2_move)) begin
          p1_x_d    = p1_x;
          p1_y_d    = p1_y;
          p2_x_d    = p2_x;
          p2_y_d    = p2_y;
          cur_p2_d  = !p1_move;
          p2_pend_d = p1_move && p2_move;
          // Head-on: p1 writes the shared cell, so p2 crashes via the map;
          // p1 must be flagged explicitly.
          head_on_d = p1_move && p2_move && (p1_x == p2_x) && (p1_y == p2_y)
                      && !out_of_bounds(p1_x, p1_y);
          state_d   = S_RD;
        end
      end
      S_RD: begin
        oob_d   = out_of_bounds(cur_x, cur_y);
        state_d = S_CMP;
      end
      S_CMP: begin
        if (hit) begin
          if (cur_p2_q) flag2_d = 1'b1;
          else          flag1_d = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_wdata = 1'b1;
        end
        if (!cur_p2_q && head_on_q) flag1_d = 1'b1;
        if (p2_pend_q) begin
          cur_p2_d  = 1'b1;
          p2_pend_d = 1'b0;
          state_d   = S_RD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (start_entry) begin
      state_d      = S_CLEAR;
      clear_addr_d = '0;
      flag1_d      = 1'b0;
      flag2_d      = 1'b0;
      p2_pend_d    = 1'b0;
      head_on_d    = 1'b0;
      ram_we       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CLEAR;
      mode_q       <= START;
      clear_addr_q <= '0;
      flag1_q      <= 1'b0;
      flag2_q      <= 1'b0;
      cur_p2_q     <= 1'b0;
      p2_pend_q    <= 1'b0;
      head_on_q    <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      clear_addr_q <= clear_addr_d;
      flag1_q      <= flag1_d;
      flag2_q      <= flag2_d;
      cur_p2_q     <= cur_p2_d;
      p2_pend_q    <= p2_pend_d;
      head_on_q    <= head_on_d;
      oob_q        <= oob_d;
    end
  end

  always_ff @(posedge clk) begin
    p1_x_q <= p1_x_d;
    p1_y_q <= p1_y_d;
    p2_x_q <= p2_x_d;
    p2_y_q <= p2_y_d;
  end

  // Single-port map, read-before-write, one access per cycle.
  always_ff @(posedge clk) begin
    if (ram_we) map_mem[ram_addr] <= ram_wdata;
    ram_q <= map_mem[ram_addr];
  end

endmodule
